window_linebuffer9x9: RTL and testbench

- Streaming producer for the 81-input inner-product stage.
- Accepts a raster-order pixel stream, one pixel per accepted cycle, and buffers the last 8 image rows in on-chip line memories.
- Maintains a 9x9 sliding window register, exposed as an 81-element array in the layout the inner-product consumer expects.
- Pulses win_valid for every window position fully inside the frame.

---
 rtl/window_linebuffer9x9.sv | 126 ++++++++++++
 tb/tb_window_linebuffer9x9.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_linebuffer9x9.sv
// Raster-stream 9x9 window generator: K-1 line memories feed a KxK shift
// window, flagging each fully in-frame window position for the MAC stage.
module window_linebuffer9x9 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 7,
    parameter int K     = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sof,
    input  logic                       pix_valid,
    input  logic [PIX_W-1:0]           pix_in,
    output logic [PIX_W-1:0]           xarray [0:K*K-1],
    output logic                       win_valid,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(K - 1);
    localparam logic [CW-1:0] COL_K    = CW'(K - 1);

    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    w_r;
    logic [CW-1:0]    w_c;
    logic             w_hit;
    logic             w_last;

    logic [PIX_W-1:0] w_lbin  [0:K-2];
    logic [PIX_W-1:0] w_lbout [0:K-2];
    logic [PIX_W-1:0] w_colv  [0:K-1];
    logic [PIX_W-1:0] r_win   [0:K*K-1];

    logic             r_wv;
    logic [RW-1:0]    r_wr;
    logic [CW-1:0]    r_wc;
    logic             r_fd;

    // sof overrides the counters so a new frame always starts at (0,0)
    assign w_r    = sof ? '0 : r_row;
    assign w_c    = sof ? '0 : r_col;
    assign w_hit  = (w_r >= ROW_K) && (w_c >= COL_K);
    assign w_last = (w_r == ROW_LAST) && (w_c == COL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (pix_valid) begin
            if (w_c == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_r == ROW_LAST) ? '0 : w_r + RW'(1);
            end else begin
                r_col <= w_c + CW'(1);
                r_row <= w_r;
            end
        end
    end

    assign w_lbin[0] = pix_in;

    genvar gk;
    generate
        for (gk = 0; gk < K - 1; gk++) begin : g_lb
            logic [PIX_W-1:0] r_mem [0:IMG_W-1];

            always_ff @(posedge clk) begin
                if (pix_valid)
                    r_mem[w_c] <= w_lbin[gk];
            end

            assign w_lbout[gk] = r_mem[w_c];

            if (gk > 0) begin : g_chain
                assign w_lbin[gk] = w_lbout[gk-1];
            end

            assign w_colv[gk] = w_lbout[K-2-gk];
        end
    endgenerate

    assign w_colv[K-1] = pix_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K * K; i++)
                r_win[i] <= '0;
        end else if (pix_valid) begin
            for (int rr = 0; rr < K; rr++) begin
                for (int cc = 0; cc < K - 1; cc++)
                    r_win[rr*K+cc] <= r_win[rr*K+cc+1];
                r_win[rr*K+K-1] <= w_colv[rr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wv <= 1'b0;
            r_wr <= '0;
            r_wc <= '0;
            r_fd <= 1'b0;
        end else begin
            r_wv <= pix_valid && w_hit;
            r_fd <= pix_valid && w_last;
            if (pix_valid && w_hit) begin
                r_wr <= w_r;
                r_wc <= w_c;
            end
        end
    end

    assign xarray     = r_win;
    assign win_valid  = r_wv;
    assign win_row    = r_wr;
    assign win_col    = r_wc;
    assign frame_done = r_fd;

endmodule

// File: tb/tb_window_linebuffer9x9.sv
// Scoreboard bench for window_linebuffer9x9: golden 9x9 crops are queued as
// pixels are driven and compared when win_valid appears.
`timescale 1ns/1ps
module tb_window_linebuffer9x9;

    localparam int W = 28;
    localparam int H = 28;
    localparam int P = 7;
    localparam int K = 9;
    localparam int N = K * K;

    logic           clk = 1'b0;
    logic           rst;
    logic           sof;
    logic           pix_valid;
    logic [P-1:0]   pix_in;
    logic [P-1:0]   xarray [0:N-1];
    logic           win_valid;
    logic [4:0]     win_row;
    logic [4:0]     win_col;
    logic           frame_done;

    window_linebuffer9x9 #(
        .IMG_W(W), .IMG_H(H), .PIX_W(P), .K(K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sof(sof),
        .pix_valid(pix_valid),
        .pix_in(pix_in),
        .xarray(xarray),
        .win_valid(win_valid),
        .win_row(win_row),
        .win_col(win_col),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [P-1:0]   img [0:H-1][0:W-1];
    int             br, bc, cur_r, cur_c, acc_r, acc_c;
    bit             acc_v;
    int             rc_q[$];
    logic [N*P-1:0] w_q[$];
    int             log_q[$];
    int             ref_q[$];
    int             win_cnt, fd_cnt;

    function automatic logic [P-1:0] pv(input int pat, input int r, input int c);
        int v;
        case (pat)
            0: v = r * 28 + c;
            1: v = r * 3 + c * 5 + 17;
            2: v = (r * 13) ^ (c * 7);
            default: v = r * 7 + c * 11 + 5;
        endcase
        return P'(v % 128);
    endfunction

    task automatic send(input bit v, input bit s, input logic [P-1:0] val);
        logic [N*P-1:0] flat;
        pix_valid = v;
        sof = v & s;
        pix_in = val;
        if (v) begin
            if (s) begin
                br = 0;
                bc = 0;
            end
            img[br][bc] = val;
            cur_r = br;
            cur_c = bc;
            if (br >= K - 1 && bc >= K - 1) begin
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        flat[(i*K+j)*P +: P] = img[br-K+1+i][bc-K+1+j];
                rc_q.push_back(br * 64 + bc);
                w_q.push_back(flat);
            end
            if (bc == W - 1) begin
                bc = 0;
                br = (br == H - 1) ? 0 : br + 1;
            end else begin
                bc++;
            end
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    always @(posedge clk) begin
        acc_v = pix_valid;
        acc_r = cur_r;
        acc_c = cur_c;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (win_valid) begin : mon_win
                int erc, h, bi;
                logic [N*P-1:0] e;
                win_cnt++;
                n_cmp++;
                if (!acc_v) begin
                    n_bad++;
                    $display("FAIL idle_valid: win_valid=1 after idle cycle, required 0");
                end
                n_cmp++;
                if (rc_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_win: got row=%0d col=%0d, required no window",
                             win_row, win_col);
                end else begin
                    erc = rc_q.pop_front();
                    e = w_q.pop_front();
                    bi = -1;
                    for (int i = 0; i < N; i++)
                        if (bi < 0 && xarray[i] !== e[i*P +: P]) bi = i;
                    if (win_row !== 5'(erc / 64) || win_col !== 5'(erc % 64) || bi >= 0) begin
                        n_bad++;
                        $display("FAIL window: got (%0d,%0d) required (%0d,%0d); elem %0d got %0d required %0d",
                                 win_row, win_col, erc / 64, erc % 64, bi,
                                 (bi >= 0) ? xarray[bi] : 7'd0,
                                 (bi >= 0) ? e[bi*P +: P] : 7'd0);
                    end
                end
                h = win_row * 64 + win_col;
                for (int i = 0; i < N; i++)
                    h = h * 31 + int'(xarray[i]);
                log_q.push_back(h);
            end
            if (frame_done) begin
                fd_cnt++;
                n_cmp++;
                if (!(acc_v && acc_r == H - 1 && acc_c == W - 1)) begin
                    n_bad++;
                    $display("FAIL frame_done_pos: after (%0d,%0d) v=%0d, required after (27,27)",
                             acc_r, acc_c, acc_v);
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        bit z;
        z = 1'b1;
        for (int i = 0; i < N; i++)
            if (xarray[i] !== '0) z = 1'b0;
        n_cmp++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_row !== 5'd0 ||
            win_col !== 5'd0 || !z) begin
            n_bad++;
            $display("FAIL %s: wv=%0b fd=%0b row=%0d col=%0d xzero=%0b, required all 0",
                     tag, win_valid, frame_done, win_row, win_col, z);
        end
    endtask

    task automatic check_counts(input string tag, input int wexp, input int fexp);
        n_cmp++;
        if (win_cnt != wexp) begin
            n_bad++;
            $display("FAIL %s_wins: got %0d required %0d", tag, win_cnt, wexp);
        end
        n_cmp++;
        if (fd_cnt != fexp) begin
            n_bad++;
            $display("FAIL %s_frame_done: got %0d required %0d", tag, fd_cnt, fexp);
        end
        n_cmp++;
        if (rc_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending: got %0d left required 0", tag, rc_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_hold");
        rst = 1'b0;
        send(0, 0, '0);
        send(0, 0, '0);
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_continuous();
        bit ev;
        win_cnt = 0;
        fd_cnt = 0;
        log_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(1, r == 0 && c == 0, pv(0, r, c));
                if ((r == 8 && c == 8) || (r == 9 && c == 27) || (r == 10 && c <= 8)) begin
                    @(negedge clk);
                    ev = !(r == 10 && c < 8);
                    n_cmp++;
                    if (win_valid !== ev) begin
                        n_bad++;
                        $display("FAIL wrap_valid(%0d,%0d): got %0b required %0b",
                                 r, c, win_valid, ev);
                    end
                    if (r == 8 && c == 8) begin
                        n_cmp++;
                        if (win_row !== 5'd8 || win_col !== 5'd8 ||
                            xarray[0] !== 7'd0 || xarray[8] !== 7'd8 ||
                            xarray[72] !== 7'd96 || xarray[80] !== 7'd104) begin
                            n_bad++;
                            $display("FAIL first_win: row=%0d col=%0d x0=%0d x8=%0d x72=%0d x80=%0d, required 8 8 0 8 96 104",
                                     win_row, win_col, xarray[0], xarray[8],
                                     xarray[72], xarray[80]);
                        end
                    end
                end
            end
        end
        send(0, 0, '0);
        send(0, 0, '0);
        check_counts("continuous", 400, 1);
        ref_q = log_q;
    endtask

    task automatic test_gaps();
        int k;
        bit same;
        win_cnt = 0;
        fd_cnt = 0;
        log_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                k = 0;
                while (k < 8 && $urandom_range(0, 1) == 1) begin
                    send(0, 0, '0);
                    k++;
                end
                send(1, r == 0 && c == 0, pv(0, r, c));
            end
        end
        send(0, 0, '0);
        send(0, 0, '0);
        check_counts("gaps", 400, 1);
        same = (log_q.size() == ref_q.size());
        for (int i = 0; same && i < log_q.size(); i++)
            if (log_q[i] != ref_q[i]) same = 1'b0;
        n_cmp++;
        if (!same) begin
            n_bad++;
            $display("FAIL gaps_sequence: got %0d windows differing from continuous %0d",
                     log_q.size(), ref_q.size());
        end
    endtask

    task automatic test_back_to_back();
        win_cnt = 0;
        fd_cnt = 0;
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    send(1, (f != 1) && r == 0 && c == 0, pv(f + 1, r, c));
        send(0, 0, '0);
        send(0, 0, '0);
        check_counts("back_to_back", 1200, 3);
    endtask

    task automatic test_sof_mid();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 15 || (r == 15 && c < 3))
                    send(1, r == 0 && c == 0, pv(1, r, c));
        win_cnt = 0;
        fd_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(1, r == 0 && c == 0, pv(2, r, c));
        send(0, 0, '0);
        send(0, 0, '0);
        check_counts("sof_mid", 400, 1);
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (r < 12 || (r == 12 && c <= 20))
                    send(1, r == 0 && c == 0, pv(0, r, c));
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("async_reset");
        rc_q.delete();
        w_q.delete();
        br = 0;
        bc = 0;
        @(negedge clk);
        rst = 1'b0;
        win_cnt = 0;
        fd_cnt = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(1, 0, pv(3, r, c));
        send(0, 0, '0);
        send(0, 0, '0);
        check_counts("reset_mid", 400, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sof = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        br = 0;
        bc = 0;
        cur_r = 0;
        cur_c = 0;
        win_cnt = 0;
        fd_cnt = 0;
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_sof_mid();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
